// File: rtl/matmul_pcpi_sequencer_pkg.sv
// Shared constants, instruction encodings and FSM states for the matmul PCPI sequencer.
// Bank base addresses and the step count all derive from the array dimension N.
package matmul_pcpi_sequencer_pkg;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int RW = 32;

    localparam logic [6:0] OPCODE = 7'b0001011;

    localparam int A_BASE    = 0;
    localparam int B_BASE    = N * N;
    localparam int BIAS_BASE = 2 * N * N;
    localparam int BANK_END  = 3 * N * N;
    localparam int RUN_STEPS = 3 * N - 1;

    typedef enum logic [2:0] {
        F_WRITE = 3'b000,
        F_READ  = 3'b010,
        F_CLEAR = 3'b101,
        F_RUN   = 3'b111
    } funct_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RUN,
        S_READ,
        S_DONE,
        S_HOLD
    } state_e;

endpackage

// File: rtl/matmul_pcpi_sequencer_if.sv
// PicoRV32 PCPI handshake bundle: the CPU drives it as master, the sequencer answers as slave.
interface matmul_pcpi_sequencer_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

endinterface

// File: rtl/matmul_pcpi_sequencer_insn_decode.sv
// Combinational custom-0 field decoder: claims only the four supported funct3 codes
// and flags operand addresses that fall inside the A/B/bias banks.
module matmul_insn_decode
    import matmul_pcpi_sequencer_pkg::*;
(
    input  logic [31:0]   insn_i,
    output logic          hit_o,
    output funct_e        op_o,
    output logic [4:0]    addr_o,
    output logic [DW-1:0] val_o,
    output logic          addr_in_range_o
);

    logic unused_insn;

    assign unused_insn     = insn_i[31];
    assign op_o            = funct_e'(insn_i[14:12]);
    assign addr_o          = insn_i[11:7];
    assign val_o           = insn_i[30:15];
    assign addr_in_range_o = (insn_i[11:7] < 5'(BANK_END));

    always_comb begin
        hit_o = 1'b0;
        if (insn_i[6:0] == OPCODE) begin
            case (insn_i[14:12])
                F_WRITE, F_READ, F_CLEAR, F_RUN: hit_o = 1'b1;
                default:                         hit_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/matmul_pcpi_sequencer.sv
// PCPI-side controller for the NxN systolic matmul array: operand writes, the skewed
// RUN schedule, result readback and all pcpi_* handshake timing.
module matmul_pcpi_sequencer
    import matmul_pcpi_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    matmul_pcpi_sequencer_if.slave pcpi,
    output logic                   opnd_we_o,
    output logic [4:0]             opnd_addr_o,
    output logic [DW-1:0]          opnd_data_o,
    output logic                   arr_en_o,
    output logic                   arr_clear_o,
    output logic [2:0]             arr_step_o,
    output logic [3:0]             res_addr_o,
    input  logic [RW-1:0]          res_data_i,
    output logic                   busy_o
);

    logic          dec_hit;
    funct_e        dec_op;
    logic [4:0]    dec_addr;
    logic [DW-1:0] dec_val;
    logic          dec_in_range;

    state_e        state_q;
    logic [2:0]    step_q, step_d;
    logic          res_valid_q;
    logic          rd_sel_q;
    logic [RW-1:0] rd_q;
    logic          ready_q, wr_q, wait_q;
    logic          opnd_we_q;
    logic [4:0]    opnd_addr_q;
    logic [DW-1:0] opnd_data_q;
    logic          arr_en_q, arr_clear_q;
    logic [2:0]    arr_step_q;

    matmul_insn_decode u_decode (
        .insn_i          (pcpi.pcpi_insn),
        .hit_o           (dec_hit),
        .op_o            (dec_op),
        .addr_o          (dec_addr),
        .val_o           (dec_val),
        .addr_in_range_o (dec_in_range)
    );

    assign step_d = step_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            res_valid_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_q        <= '0;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            wait_q      <= 1'b0;
            opnd_we_q   <= 1'b0;
            opnd_addr_q <= '0;
            opnd_data_q <= '0;
            arr_en_q    <= 1'b0;
            arr_clear_q <= 1'b0;
            arr_step_q  <= '0;
        end else begin
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            rd_sel_q    <= 1'b0;
            opnd_we_q   <= 1'b0;
            arr_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pcpi.pcpi_valid && dec_hit) begin
                        case (dec_op)
                            F_WRITE, F_CLEAR: begin
                                state_q     <= S_WRITE;
                                ready_q     <= 1'b1;
                                res_valid_q <= 1'b0;
                                opnd_we_q   <= (dec_op == F_WRITE) && dec_in_range;
                                opnd_addr_q <= dec_addr;
                                opnd_data_q <= dec_val;
                            end
                            F_READ: begin
                                state_q  <= S_READ;
                                ready_q  <= 1'b1;
                                wr_q     <= 1'b1;
                                rd_q     <= '0;
                                rd_sel_q <= res_valid_q && (dec_addr < 5'(N * N));
                            end
                            F_RUN: begin
                                state_q     <= S_RUN;
                                step_q      <= '0;
                                wait_q      <= 1'b1;
                                arr_en_q    <= 1'b1;
                                arr_clear_q <= 1'b1;
                                arr_step_q  <= '0;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    // The CPU withdrawing pcpi_valid mid-run is an abort: stop the array, no reply.
                    if (!pcpi.pcpi_valid) begin
                        state_q     <= S_IDLE;
                        wait_q      <= 1'b0;
                        arr_en_q    <= 1'b0;
                        arr_step_q  <= '0;
                        res_valid_q <= 1'b0;
                    end else if (step_q == 3'(RUN_STEPS - 1)) begin
                        state_q     <= S_DONE;
                        wait_q      <= 1'b0;
                        arr_en_q    <= 1'b0;
                        arr_step_q  <= '0;
                        ready_q     <= 1'b1;
                        wr_q        <= 1'b1;
                        rd_q        <= RW'(RUN_STEPS);
                        res_valid_q <= 1'b1;
                    end else begin
                        step_q     <= step_d;
                        arr_step_q <= step_d;
                    end
                end
                S_WRITE, S_READ, S_DONE: begin
                    state_q <= S_HOLD;
                    rd_q    <= '0;
                end
                S_HOLD: begin
                    if (!pcpi.pcpi_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The array's result port has one cycle of read latency, so its output is muxed in during READ.
    assign pcpi.pcpi_rd    = rd_sel_q ? res_data_i : rd_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_wait  = wait_q;

    assign opnd_we_o   = opnd_we_q;
    assign opnd_addr_o = opnd_addr_q;
    assign opnd_data_o = opnd_data_q;
    assign arr_en_o    = arr_en_q;
    assign arr_clear_o = arr_clear_q;
    assign arr_step_o  = arr_step_q;
    assign res_addr_o  = dec_addr[3:0];
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_matmul_pcpi_sequencer.sv
// Self-checking bench for matmul_pcpi_sequencer: vector table, hand-written RUN/abort/reset
// sequences and randomized instructions against a behavioural model of the result store.
module tb_matmul_pcpi_sequencer;

    localparam logic [6:0] OPC      = 7'b0001011;
    localparam int         NN       = 9;
    localparam int         BANKS    = 27;
    localparam int         STEPS    = 8;

    logic        clk;
    logic        resetn;
    logic        opndWe;
    logic [4:0]  opndAddr;
    logic [15:0] opndData;
    logic        arrEn;
    logic        arrClear;
    logic [2:0]  arrStep;
    logic [3:0]  resAddr;
    logic [31:0] resData;
    logic        busy;

    logic [31:0] cMem [16];
    logic        modelResValid;
    int          testsRun;
    int          failCount;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  addr;
        logic [15:0] val;
        logic        expWe;
        logic        expReady;
        logic        expWr;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [7];

    matmul_pcpi_sequencer_if bus ();

    matmul_pcpi_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .pcpi        (bus),
        .opnd_we_o   (opndWe),
        .opnd_addr_o (opndAddr),
        .opnd_data_o (opndData),
        .arr_en_o    (arrEn),
        .arr_clear_o (arrClear),
        .arr_step_o  (arrStep),
        .res_addr_o  (resAddr),
        .res_data_i  (resData),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the array's registered result port.
    always @(posedge clk) resData <= cMem[resAddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic dropAndIdle();
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        tick();
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] addr,
                                 input logic [15:0] val, input logic expWe, input logic expReady,
                                 input logic expWr, input logic [31:0] expRd);
        bus.pcpi_insn  = {1'b0, val, f3, addr, opc};
        bus.pcpi_valid = 1'b1;
        #1;
        if (opc == OPC && f3 == 3'b010)
            checkOutput("read_res_addr", 32'(resAddr), 32'(addr[3:0]));
        tick();
        checkOutput("opnd_we", 32'(opndWe), 32'(expWe));
        if (expWe) begin
            checkOutput("opnd_addr", 32'(opndAddr), 32'(addr));
            checkOutput("opnd_data", 32'(opndData), 32'(val));
        end
        checkOutput("ready", 32'(bus.pcpi_ready), 32'(expReady));
        checkOutput("wr", 32'(bus.pcpi_wr), 32'(expWr));
        checkOutput("wait_low", 32'(bus.pcpi_wait), 32'd0);
        if (expWr)
            checkOutput("rd", bus.pcpi_rd, expRd);
        tick();
        checkOutput("ready_pulse", 32'(bus.pcpi_ready), 32'd0);
        dropAndIdle();
    endtask

    task automatic runSequence(input int hold);
        bus.pcpi_insn  = {1'b0, 16'h0, 3'b111, 5'd0, OPC};
        bus.pcpi_valid = 1'b1;
        tick();
        for (int k = 0; k < STEPS; k++) begin
            checkOutput("run_en", 32'(arrEn), 32'd1);
            checkOutput("run_step", 32'(arrStep), 32'(k));
            checkOutput("run_clear", 32'(arrClear), 32'(k == 0));
            checkOutput("run_wait", 32'(bus.pcpi_wait), 32'd1);
            checkOutput("run_no_ready", 32'(bus.pcpi_ready), 32'd0);
            tick();
        end
        checkOutput("done_ready", 32'(bus.pcpi_ready), 32'd1);
        checkOutput("done_wr", 32'(bus.pcpi_wr), 32'd1);
        checkOutput("done_rd", bus.pcpi_rd, 32'(3 * 3 - 1));
        checkOutput("done_wait", 32'(bus.pcpi_wait), 32'd0);
        checkOutput("done_en", 32'(arrEn), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput("hold_no_ready", 32'(bus.pcpi_ready), 32'd0);
            checkOutput("hold_no_run", 32'(arrEn), 32'd0);
            checkOutput("hold_busy", 32'(busy), 32'd1);
        end
        modelResValid = 1'b1;
        dropAndIdle();
    endtask

    // Reference behaviour: legality, bank range and whether a completed RUN result is held.
    task automatic modelStep(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] addr,
                             input logic [15:0] val);
        bit legal;
        legal = (opc == OPC) && (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b101 || f3 == 3'b111);
        if (!legal) begin
            applyStimulus(opc, f3, addr, val, 1'b0, 1'b0, 1'b0, 32'd0);
        end else if (f3 == 3'b111) begin
            runSequence(1);
        end else if (f3 == 3'b010) begin
            applyStimulus(opc, f3, addr, val, 1'b0, 1'b1, 1'b1,
                          (modelResValid && int'(addr) < NN) ? cMem[addr[3:0]] : 32'd0);
        end else begin
            applyStimulus(opc, f3, addr, val, (f3 == 3'b000) && (int'(addr) < BANKS), 1'b1, 1'b0, 32'd0);
            modelResValid = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] illegal [4];
        testsRun      = 0;
        failCount     = 0;
        modelResValid = 1'b0;
        illegal       = '{3'b001, 3'b011, 3'b100, 3'b110};
        for (int i = 0; i < 16; i++) cMem[i] = $urandom;
        cMem[5] = 32'h1234;

        vecs[0] = '{OPC, 3'b000, 5'd4, 16'hFFFB, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[1] = '{OPC, 3'b000, 5'd30, 16'h0055, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{OPC, 3'b000, 5'd26, 16'h1234, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[3] = '{OPC, 3'b101, 5'd3, 16'h0001, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[4] = '{OPC, 3'b010, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 32'd0};
        vecs[5] = '{OPC, 3'b001, 5'd2, 16'h0007, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[6] = '{7'b0110011, 3'b000, 5'd2, 16'h0007, 1'b0, 1'b0, 1'b0, 32'd0};

        resetn         = 1'b0;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        tick();
        tick();
        tick();
        checkOutput("rst_ready", 32'(bus.pcpi_ready), 32'd0);
        checkOutput("rst_wr", 32'(bus.pcpi_wr), 32'd0);
        checkOutput("rst_rd", bus.pcpi_rd, 32'd0);
        checkOutput("rst_wait", 32'(bus.pcpi_wait), 32'd0);
        checkOutput("rst_opnd", {15'd0, opndWe, opndAddr, opndData}, 32'd0);
        checkOutput("rst_arr", {26'd0, arrEn, arrClear, arrStep}, 32'd0);
        checkOutput("rst_res_addr", 32'(resAddr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i].opc, vecs[i].f3, vecs[i].addr, vecs[i].val,
                          vecs[i].expWe, vecs[i].expReady, vecs[i].expWr, vecs[i].expRd);

        // Full RUN, then CPU keeps valid up for three cycles: must not be accepted twice.
        runSequence(3);
        applyStimulus(OPC, 3'b010, 5'd5, 16'h0, 1'b0, 1'b1, 1'b1, 32'h1234);
        applyStimulus(OPC, 3'b010, 5'd12, 16'h0, 1'b0, 1'b1, 1'b1, 32'd0);

        // Abort at step 3 drops the array enable, never replies and invalidates results.
        bus.pcpi_insn  = {1'b0, 16'h0, 3'b111, 5'd0, OPC};
        bus.pcpi_valid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_step", 32'(arrStep), 32'(k));
            if (k < 3) tick();
        end
        bus.pcpi_valid = 1'b0;
        tick();
        checkOutput("abort_en", 32'(arrEn), 32'd0);
        checkOutput("abort_wait", 32'(bus.pcpi_wait), 32'd0);
        for (int h = 0; h < 3; h++) begin
            checkOutput("abort_no_ready", 32'(bus.pcpi_ready), 32'd0);
            tick();
        end
        modelResValid = 1'b0;
        dropAndIdle();
        applyStimulus(OPC, 3'b010, 5'd5, 16'h0, 1'b0, 1'b1, 1'b1, 32'd0);
        runSequence(1);

        // Synchronous reset in the middle of a RUN.
        bus.pcpi_insn  = {1'b0, 16'h0, 3'b111, 5'd0, OPC};
        bus.pcpi_valid = 1'b1;
        tick();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        checkOutput("rstrun_en", 32'(arrEn), 32'd0);
        checkOutput("rstrun_ready", 32'(bus.pcpi_ready), 32'd0);
        checkOutput("rstrun_busy", 32'(busy), 32'd0);
        resetn        = 1'b1;
        modelResValid = 1'b0;
        dropAndIdle();

        for (int i = 0; i < 60; i++) begin
            int          sel;
            logic [6:0]  opc;
            logic [2:0]  f3;
            logic [4:0]  addr;
            logic [15:0] val;
            sel  = $urandom_range(0, 9);
            opc  = OPC;
            addr = 5'($urandom_range(0, 31));
            val  = 16'($urandom);
            f3   = 3'b000;
            case (sel)
                0, 1:    f3 = 3'b000;
                2:       f3 = 3'b101;
                3, 4, 5: begin f3 = 3'b010; addr = 5'($urandom_range(0, 12)); end
                6, 7:    f3 = 3'b111;
                8:       f3 = illegal[$urandom_range(0, 3)];
                default: begin opc = OPC ^ 7'($urandom_range(1, 127)); f3 = 3'($urandom); end
            endcase
            if (i % 5 == 0) cMem[$urandom_range(0, 15)] = $urandom;
            modelStep(opc, f3, addr, val);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
